tile_matmul_agu_v2: RTL

Single-block successor to the two-stage tiled matmul address generator. It walks a full batched GEMM C[b] = A[b]·B[b] (M×K · K×N) in tiles of TM×TN×TK and emits one element address per accepted beat for the A tile, the B tile and, on the last K tile only, the C tile.

---
 rtl/tile_matmul_agu_v2.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_matmul_agu_v2.sv
// tile_matmul_agu_v2 : address generator for a batched, tiled GEMM C[b] = A[b]*B[b].
// Walks b -> m0 -> n0 -> k0 tiles and streams one element byte address per accepted beat.
// Each tile emits its A sub-block, then its B sub-block, and its C sub-block on the last K tile only.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    job start pulse, honoured only when idle
//   M, N, K                  problem dimensions in elements
//   TM, TN, TK               tile sizes (0 behaves as 1)
//   batch                    number of batches
//   lda, ldb, ldc            leading dimensions in elements
//   baseA/B/C, strideA/B/C   byte base addresses and byte batch strides
//   transB                   1: B is stored N x K
//   elem_shift               log2 of the element size in bytes
//   o_addr, addr_id, o_last  address beat: matrix id (0=A 1=B 2=C), last beat of the phase
//   valid, ready             beat handshake
//   busy, done               job in progress / one-cycle end-of-job pulse
module tile_matmul_agu_v2 #(
   parameter int ADDR_WIDTH  = 32,
   parameter int IDX_WIDTH   = 8,
   parameter int BATCH_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [IDX_WIDTH-1:0]   M,
   input  logic [IDX_WIDTH-1:0]   N,
   input  logic [IDX_WIDTH-1:0]   K,
   input  logic [IDX_WIDTH-1:0]   TM,
   input  logic [IDX_WIDTH-1:0]   TN,
   input  logic [IDX_WIDTH-1:0]   TK,
   input  logic [BATCH_WIDTH-1:0] batch,
   input  logic [IDX_WIDTH-1:0]   lda,
   input  logic [IDX_WIDTH-1:0]   ldb,
   input  logic [IDX_WIDTH-1:0]   ldc,
   input  logic [ADDR_WIDTH-1:0]  baseA,
   input  logic [ADDR_WIDTH-1:0]  baseB,
   input  logic [ADDR_WIDTH-1:0]  baseC,
   input  logic [ADDR_WIDTH-1:0]  strideA,
   input  logic [ADDR_WIDTH-1:0]  strideB,
   input  logic [ADDR_WIDTH-1:0]  strideC,
   input  logic                   transB,
   input  logic [1:0]             elem_shift,
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic [1:0]             addr_id,
   output logic                   o_last,
   output logic                   valid,
   input  logic                   ready,
   output logic                   busy,
   output logic                   done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_A    = 3'd1;
   localparam logic [2:0] S_B    = 3'd2;
   localparam logic [2:0] S_C    = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   localparam logic [IDX_WIDTH-1:0] IDX_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [IDX_WIDTH-1:0] nz(input logic [IDX_WIDTH-1:0] t);
      return (t == '0) ? IDX_ONE : t;
   endfunction

   // Edge clipping: min(t, dim - off); callers guarantee off < dim.
   function automatic logic [IDX_WIDTH-1:0] clip(input logic [IDX_WIDTH-1:0] t,
                                                 input logic [IDX_WIDTH-1:0] dim,
                                                 input logic [IDX_WIDTH-1:0] off);
      logic [IDX_WIDTH-1:0] rem;
      rem = dim - off;
      return (t < rem) ? t : rem;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] ext(input logic [IDX_WIDTH-1:0] v);
      return {{(ADDR_WIDTH-IDX_WIDTH){1'b0}}, v};
   endfunction

   logic [2:0]             state;
   // latched job configuration
   logic [IDX_WIDTH-1:0]   m_r, n_r, k_r, tm_r, tn_r, tk_r, lda_r, ldb_r, ldc_r;
   logic [BATCH_WIDTH-1:0] batch_r;
   logic [ADDR_WIDTH-1:0]  base_a_r, base_b_r, base_c_r, stride_a_r, stride_b_r, stride_c_r;
   logic                   transb_r;
   logic [1:0]             shift_r;
   // loop position
   logic [BATCH_WIDTH-1:0] b_r;
   logic [IDX_WIDTH-1:0]   m0_r, n0_r, k0_r, etm_r, etn_r, etk_r, cnt_o, cnt_i;

   logic [IDX_WIDTH-1:0]   outer_lim, inner_lim;
   logic [ADDR_WIDTH-1:0]  row, col, ld, base, stride, elem_off, addr_c;
   logic                   last_beat, inner_wrap, k_last;

   // Per-phase walk: outer/inner counters map onto (row, col) of the active matrix.
   always_comb begin
      outer_lim = IDX_ONE;
      inner_lim = IDX_ONE;
      row       = '0;
      col       = '0;
      ld        = '0;
      base      = '0;
      stride    = '0;
      case (state)
         S_A: begin
            outer_lim = etm_r;  inner_lim = etk_r;
            row = ext(m0_r) + ext(cnt_o);  col = ext(k0_r) + ext(cnt_i);
            ld = ext(lda_r);  base = base_a_r;  stride = stride_a_r;
         end
         S_B: begin
            if (transb_r) begin
               outer_lim = etn_r;  inner_lim = etk_r;
               row = ext(n0_r) + ext(cnt_o);  col = ext(k0_r) + ext(cnt_i);
            end else begin
               outer_lim = etk_r;  inner_lim = etn_r;
               row = ext(k0_r) + ext(cnt_o);  col = ext(n0_r) + ext(cnt_i);
            end
            ld = ext(ldb_r);  base = base_b_r;  stride = stride_b_r;
         end
         S_C: begin
            outer_lim = etm_r;  inner_lim = etn_r;
            row = ext(m0_r) + ext(cnt_o);  col = ext(n0_r) + ext(cnt_i);
            ld = ext(ldc_r);  base = base_c_r;  stride = stride_c_r;
         end
         default: ;
      endcase
   end

   assign elem_off   = row * ld + col;
   assign addr_c     = base + {{(ADDR_WIDTH-BATCH_WIDTH){1'b0}}, b_r} * stride + (elem_off << shift_r);
   assign inner_wrap = (cnt_i == inner_lim - IDX_ONE);
   assign last_beat  = inner_wrap && (cnt_o == outer_lim - IDX_ONE);
   assign k_last     = ({1'b0, k0_r} + {1'b0, etk_r}) == {1'b0, k_r};

   // Loop advance evaluated in NEXT: k0 innermost, batch outermost.
   logic [IDX_WIDTH:0]     k_sum, n_sum, m_sum;
   logic [BATCH_WIDTH:0]   b_sum;
   logic [IDX_WIDTH-1:0]   nk0, nn0, nm0;
   logic [BATCH_WIDTH-1:0] nb;
   logic                   all_done;

   assign k_sum = {1'b0, k0_r} + {1'b0, tk_r};
   assign n_sum = {1'b0, n0_r} + {1'b0, tn_r};
   assign m_sum = {1'b0, m0_r} + {1'b0, tm_r};
   assign b_sum = {1'b0, b_r} + {{BATCH_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      nk0      = k0_r;
      nn0      = n0_r;
      nm0      = m0_r;
      nb       = b_r;
      all_done = 1'b0;
      if (k_sum < {1'b0, k_r}) begin
         nk0 = k_sum[IDX_WIDTH-1:0];
      end else begin
         nk0 = '0;
         if (n_sum < {1'b0, n_r}) begin
            nn0 = n_sum[IDX_WIDTH-1:0];
         end else begin
            nn0 = '0;
            if (m_sum < {1'b0, m_r}) begin
               nm0 = m_sum[IDX_WIDTH-1:0];
            end else begin
               nm0 = '0;
               if (b_sum < {1'b0, batch_r}) nb = b_sum[BATCH_WIDTH-1:0];
               else                         all_done = 1'b1;
            end
         end
      end
   end

   // Only the FSM state is reset; loop and config registers are always written before use.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               m_r <= M;  n_r <= N;  k_r <= K;
               tm_r <= nz(TM);  tn_r <= nz(TN);  tk_r <= nz(TK);
               batch_r <= batch;
               lda_r <= lda;  ldb_r <= ldb;  ldc_r <= ldc;
               base_a_r <= baseA;  base_b_r <= baseB;  base_c_r <= baseC;
               stride_a_r <= strideA;  stride_b_r <= strideB;  stride_c_r <= strideC;
               transb_r <= transB;  shift_r <= elem_shift;
               b_r <= '0;  m0_r <= '0;  n0_r <= '0;  k0_r <= '0;
               cnt_o <= '0;  cnt_i <= '0;
               etm_r <= clip(nz(TM), M, '0);
               etn_r <= clip(nz(TN), N, '0);
               etk_r <= clip(nz(TK), K, '0);
               state <= (M == '0 || N == '0 || K == '0 || batch == '0) ? S_FIN : S_A;
            end
            S_A, S_B, S_C: if (ready) begin
               if (last_beat) begin
                  cnt_o <= '0;
                  cnt_i <= '0;
                  if (state == S_A)      state <= S_B;
                  else if (state == S_B) state <= k_last ? S_C : S_NEXT;
                  else                   state <= S_NEXT;
               end else if (inner_wrap) begin
                  cnt_i <= '0;
                  cnt_o <= cnt_o + IDX_ONE;
               end else begin
                  cnt_i <= cnt_i + IDX_ONE;
               end
            end
            S_NEXT: begin
               k0_r  <= nk0;  n0_r <= nn0;  m0_r <= nm0;  b_r <= nb;
               etm_r <= clip(tm_r, m_r, nm0);
               etn_r <= clip(tn_r, n_r, nn0);
               etk_r <= clip(tk_r, k_r, nk0);
               state <= all_done ? S_FIN : S_A;
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode directly from registered state, so they hold while valid && !ready.
   assign valid   = (state == S_A) || (state == S_B) || (state == S_C);
   assign o_addr  = valid ? addr_c : '0;
   assign o_last  = valid && last_beat;
   assign addr_id = (state == S_B) ? 2'd1 : (state == S_C) ? 2'd2 : 2'd0;
   assign busy    = valid || (state == S_NEXT);
   assign done    = (state == S_FIN);

endmodule
